// File: rtl/addsub_pkg.sv
// Shared types for the add/sub arbiter: FSM state encoding and operation codes.
// No logic; imported by addsub_core and addsub_arbiter.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/addsub_core.sv
// Two's-complement add/sub with carry/no-borrow and signed overflow; purely combinational.
// Latency 0, no backpressure. ADDSUB_SATURATE_EN clamps the result on overflow.
module addsub_core
  import addsub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] res,
  output logic             cout,
  output logic             overflow
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;

  always_comb begin
    b_eff = (sub == OP_SUB) ? ~b : b;
    sum   = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
    cout  = sum[WIDTH];
    if (sub == OP_SUB)
      overflow = (a[WIDTH-1] != b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    else
      overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    res = sum[WIDTH-1:0];
`ifdef ADDSUB_SATURATE_EN
    // Overflow direction always follows the sign of a.
    if (overflow)
      res = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
  end

endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter feeding one shared add/sub unit; IDLE -> EXEC -> RESP.
// Response 2 cycles after acceptance; rsp_* held while rsp_ready low, no grants until handshake.
module addsub_arbiter
  import addsub_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_sub,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_res,
  output logic                  rsp_cout,
  output logic                  rsp_overflow
);

  state_t           state;
  logic [IDW-1:0]   last_grant;
  logic [IDW-1:0]   gnt_idx;
  logic [IDW-1:0]   cand;
  logic             gnt_found;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_sub;
  logic [IDW-1:0]   op_id;
  logic [WIDTH-1:0] core_res;
  logic             core_cout;
  logic             core_ovf;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = last_grant;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(last_grant) + k) % NREQ);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (rst_n && state == IDLE && gnt_found)
      req_ready = NREQ'(1) << gnt_idx;
  end

  addsub_core #(.WIDTH(WIDTH)) u_core (
    .a        (op_a),
    .b        (op_b),
    .sub      (op_sub),
    .res      (core_res),
    .cout     (core_cout),
    .overflow (core_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      last_grant   <= IDW'(NREQ - 1);
      op_a         <= '0;
      op_b         <= '0;
      op_sub       <= 1'b0;
      op_id        <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_res      <= '0;
      rsp_cout     <= 1'b0;
      rsp_overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_found) begin
            op_a       <= req_a[gnt_idx*WIDTH +: WIDTH];
            op_b       <= req_b[gnt_idx*WIDTH +: WIDTH];
            op_sub     <= req_sub[gnt_idx];
            op_id      <= gnt_idx;
            last_grant <= gnt_idx;
            state      <= EXEC;
          end
        end
        EXEC: begin
          rsp_res      <= core_res;
          rsp_cout     <= core_cout;
          rsp_overflow <= core_ovf;
          rsp_id       <= op_id;
          rsp_valid    <= 1'b1;
          state        <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/addsub_arbiter.md
ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

Interface
REQ-001 Parameters SHALL be: WIDTH, 4, operand/result width in bits (two's complement); NREQ, 4, number of requesters (2..8).
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert and active-low.
REQ-004 req_valid  input  NREQ  per-requester operation request.
REQ-005 req_ready  output  NREQ  per-requester acceptance; at most one bit high per cycle.
REQ-006 req_a, req_b  input  NREQ*WIDTH each  operands; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-007 req_sub  input  NREQ  per-requester op: 0 = a+b, 1 = a-b.
REQ-008 rsp_valid  output  1  result available.
REQ-009 rsp_ready  input  1  result consumer ready.
REQ-010 rsp_id  output  clog2(NREQ)  index of the requester that owns the result.
REQ-011 rsp_res  output  WIDTH  result.
REQ-012 rsp_cout  output  1  carry out (add); no-borrow (sub).
REQ-013 rsp_overflow  output  1  signed overflow flag.

Function
REQ-014 The FSM SHALL have three states: IDLE, EXEC, RESP.
REQ-015 IDLE: if any req_valid is high, the block SHALL grant one requester, assert req_ready for it only (combinational, same cycle), capture a/b/sub/id, and go to EXEC. Otherwise it SHALL stay in IDLE with req_ready all zero.
REQ-016 Arbitration SHALL be round-robin. Search starts at (last_grant+1) mod NREQ. last_grant updates on every accepted request.
REQ-017 EXEC: the captured operation SHALL be computed and registered into rsp_* outputs; the FSM SHALL go to RESP unconditionally.
REQ-018 RESP: rsp_valid SHALL be high. On rsp_valid & rsp_ready the FSM SHALL return to IDLE.
REQ-019 While in RESP, rsp_* SHALL hold stable until the handshake completes.
REQ-020 req_ready SHALL be zero in EXEC and RESP.
REQ-021 Latency: a request accepted in cycle N SHALL produce rsp_valid in cycle N+2. Maximum throughput SHALL be one operation per 3 cycles.
REQ-022 Add: {rsp_cout, rsp_res} = a + b (WIDTH+1-bit sum). Overflow SHALL be set when a and b have equal MSBs and res MSB differs.
REQ-023 Sub: {rsp_cout, rsp_res} = a + ~b + 1. Overflow SHALL be set when a and b MSBs differ and res MSB differs from a MSB.
REQ-024 req_valid deasserted by a requester before it is granted SHALL simply drop that request; no state is kept per requester.

Reset
REQ-025 While rst_n is low: FSM = IDLE, last_grant = NREQ-1 (first grant goes to requester 0), and rsp_valid, rsp_id, rsp_res, rsp_cout, rsp_overflow, req_ready all 0.
REQ-026 Reset asserted in EXEC or RESP SHALL discard the in-flight operation with no response.

Configuration
REQ-027 Macro ADDSUB_SATURATE_EN defined: when overflow = 1, rsp_res SHALL saturate. If a MSB = 0, it SHALL be 0 followed by all ones (most positive). If a MSB = 1, it SHALL be 1 followed by all zeros (most negative). rsp_overflow SHALL still report 1 and rsp_cout SHALL be unchanged.
REQ-028 Macro ADDSUB_SATURATE_EN undefined: rsp_res SHALL be the wrapped result.

Structure
REQ-029 Package addsub_pkg SHALL hold the FSM state enum and the op encodings (OP_ADD = 0, OP_SUB = 1).
REQ-030 Arithmetic SHALL live in one combinational sub-module, addsub_core (a, b, sub -> res, cout, overflow, saturation under the macro). Arbitration and the FSM SHALL stay in addsub_arbiter.

Verification (WIDTH=4, NREQ=4)
REQ-031 Requester 2 issues add 3+4. Required response: rsp_id=2, res=0111, cout=0, ovf=0, rsp_valid high exactly 2 cycles after acceptance.
REQ-032 Add 5+4. Required response: res=1001, ovf=1 without the macro; res=0111, ovf=1 with ADDSUB_SATURATE_EN.
REQ-033 Sub 2-3 must give res=1111, cout=0, ovf=0. Sub -8-1 (1000-0001) must give res=0111, ovf=1 without the macro, and res=1000 with it.
REQ-034 All four req_valid held high from reset with rsp_ready=1. Grant order SHALL be 0,1,2,3,0, with one req_ready pulse per 3 cycles.
REQ-035 Hold rsp_ready=0 for 5 cycles in RESP. rsp_* SHALL stay stable, req_ready SHALL stay 0, and exactly one response SHALL complete when rsp_ready rises.
REQ-036 Drive rst_n low during RESP. rsp_valid SHALL drop immediately. After release, the first grant SHALL go to requester 0 and no stale response SHALL appear.
